// File: rtl/dmem_param.sv
// dmem_param: word memory with byte-lane writes, reset-time fill (Mem[i] = i) and a 1- or 2-cycle registered read path.
// Optional macro DMEM_BOUNDS_CHECK_EN rejects misaligned/out-of-range requests; without it addresses wrap modulo DEPTH.
module dmem_param #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 64,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Control,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic [DATA_WIDTH/8-1:0] ByteEnable,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    ReadValid,
    output logic                    Busy,
    output logic                    Error
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {INIT = 1'b0, IDLE = 1'b1} state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [IDX_W-1:0]      cnt_r;
    logic [IDX_W-1:0]      cnt_nxt_s;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] word_addr_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  bad_addr_s;
    logic                  req_s;
    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  err_s;
    logic                  v1_r;
    logic                  e1_r;
    logic [DATA_WIDTH-1:0] d1_r;

    // State and init-counter register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= INIT;
            cnt_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: walk the counter through every word, then settle in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            INIT: begin
                if (cnt_r == IDX_W'(DEPTH - 1)) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s = INIT;
                    cnt_nxt_s   = cnt_r + IDX_W'(1);
                end
            end
            IDLE: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = cnt_r;
            end
            default: begin
                state_nxt_s = INIT;
                cnt_nxt_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Request decode: word index, address legality and accept/reject qualification.
    always_comb begin
        word_addr_s = Address >> OFF_W;
`ifdef DMEM_BOUNDS_CHECK_EN
        bad_addr_s  = ((Address & ADDR_WIDTH'(BYTES - 1)) != {ADDR_WIDTH{1'b0}}) ||
                      (word_addr_s >= ADDR_WIDTH'(DEPTH));
        idx_s       = word_addr_s[IDX_W-1:0];
`else
        bad_addr_s  = 1'b0;
        idx_s       = IDX_W'(word_addr_s % ADDR_WIDTH'(DEPTH));
`endif
        // Reset in the same cycle as a request wins; nothing is accepted or flagged.
        req_s    = !Reset && (state_r == IDLE) && Control;
        rd_acc_s = req_s && MemRead && !MemWrite && !bad_addr_s;
        wr_acc_s = req_s && MemWrite && !MemRead && !bad_addr_s;
        err_s    = req_s && ((MemRead && MemWrite) || ((MemRead || MemWrite) && bad_addr_s));
    end

    // Memory array: init fill during INIT, byte-lane merge on accepted writes.
    always_ff @(posedge Clock) begin
        if (!Reset && (state_r == INIT)) begin
            mem_r[cnt_r] <= DATA_WIDTH'(cnt_r);
        end else if (wr_acc_s) begin
            for (int k = 0; k < BYTES; k++) begin
                if (ByteEnable[k]) begin
                    mem_r[idx_s][8*k +: 8] <= WriteData[8*k +: 8];
                end
            end
        end
    end

    // First read stage; data is forced to zero whenever the stage is not valid.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            v1_r <= 1'b0;
            e1_r <= 1'b0;
            d1_r <= {DATA_WIDTH{1'b0}};
        end else begin
            v1_r <= rd_acc_s;
            e1_r <= err_s;
            d1_r <= rd_acc_s ? mem_r[idx_s] : {DATA_WIDTH{1'b0}};
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  v2_r;
            logic                  e2_r;
            logic [DATA_WIDTH-1:0] d2_r;

            // Second read stage, flushed by Reset like the first.
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    v2_r <= 1'b0;
                    e2_r <= 1'b0;
                    d2_r <= {DATA_WIDTH{1'b0}};
                end else begin
                    v2_r <= v1_r;
                    e2_r <= e1_r;
                    d2_r <= d1_r;
                end
            end

            assign ReadValid = v2_r;
            assign Error     = e2_r;
            assign ReadData  = d2_r;
        end else begin : g_lat1
            assign ReadValid = v1_r;
            assign Error     = e1_r;
            assign ReadData  = d1_r;
        end
    endgenerate

    assign Busy = (state_r == INIT);

endmodule
